dmvm_stream: RTL and testbench
==============================

Name: dmvm_stream

Overview:
- Next-generation attention-coefficient engine for the GAT datapath. Consumes a streamed sub-graph of WH rows (source node first, then neighbours) and computes per-node dot products against the split attention vector a = {a1, a2}.
- Forms e_i = s1_src + s2_i and applies ReLU, or optionally LeakyReLU, then quantises with saturation.
- Emits coefficients as a back-pressured stream instead of a flat array.
- Sits between the WH producer and the softmax stage.

Parameters:
- DATA_WIDTH, 8, width of a elements and output coefficients (signed)
- WH_DATA_WIDTH, 12, width of one WH element (signed)
- DMVM_DATA_WIDTH, 20, accumulator width for products and dot products (signed)
- NUM_FEAT, 16, features per WH row = length of a1 and a2; power of 2, >= 2
- MAX_NODES, 168, maximum nodes per sub-graph (source included)
- NODE_W, $clog2(MAX_NODES+1), width of node count and index
- LEAKY_SHIFT, 3, negative-slope shift (slope = 2^-LEAKY_SHIFT); used only with the optional feature

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- a_valid_i  in  1  load pulse for attention vector
- a_i  in  2*NUM_FEAT*DATA_WIDTH  packed a; element k at bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]; k < NUM_FEAT is a1, the rest is a2
- wh_valid_i  in  1  WH row valid
- wh_ready_o  out  1  WH row ready
- wh_data_i  in  NUM_FEAT*WH_DATA_WIDTH  packed WH row, same element ordering as a_i
- wh_src_i  in  1  row is the source node (must be the first row of a sub-graph)
- wh_nodes_i  in  NODE_W  node count of the sub-graph, sampled on the source row only
- coef_valid_o  out  1  coefficient valid
- coef_ready_i  in  1  downstream ready
- coef_data_o  out  DATA_WIDTH  signed coefficient
- coef_idx_o  out  NODE_W  node index of coef_data_o
- coef_last_o  out  1  final coefficient of the sub-graph
- graph_done_o  out  1  one-cycle pulse after the last coefficient handshake
- proto_err_o  out  1  one-cycle pulse on a protocol violation
- busy_o  out  1  high whenever state != IDLE and != ACCUM with zero rows

Behaviour:
- Reset (rst_n=0 at a clk edge; also mid-operation): state = IDLE.
  - All outputs 0, a registers cleared, row/emit counters cleared.
  - Score buffer contents are don't-care.
- FSM states and transitions:
  - IDLE: wh_ready_o=0. On a_valid_i, capture a_i and go to ACCUM.
  - ACCUM: wh_ready_o=1 while rows_rx < nodes (before the source row, nodes is treated as unknown and ready=1). Each handshake pushes one row into the pipeline; rows_rx++. When the final row is accepted, go to DRAIN.
  - DRAIN: wh_ready_o=0. Wait until the last row's score is written to the buffer, then go to EMIT.
  - EMIT: stream idx 0..nodes-1, one per coef_valid_o & coef_ready_i handshake.
    - coef_last_o = (idx == nodes-1).
    - coef_data_o and coef_idx_o stay stable while valid and not ready.
    - After the last handshake: pulse graph_done_o, clear rows_rx, return to ACCUM (a is retained).
- a_valid_i: accepted in IDLE, or in ACCUM with rows_rx == 0; ignored in all other states.
- Protocol errors: each pulses proto_err_o for one cycle, and the offending row is consumed and discarded (handshake completes, no state change).
  - First row without wh_src_i.
  - wh_src_i on a non-first row.
  - wh_nodes_i == 0 or wh_nodes_i > MAX_NODES on the source row.
- Datapath pipeline, one row per cycle, no bubbles:
  - Stage 0: NUM_FEAT signed products a1[k]*WH[k] and a2[k]*WH[k], sign-extended to DMVM_DATA_WIDTH.
  - Stages 1..log2(NUM_FEAT): pairwise adder tree, wrapping modulo 2^DMVM_DATA_WIDTH.
  - Row-to-score latency: log2(NUM_FEAT)+1 cycles (5 at default).
- Score storage:
  - Source row: s1_src is kept in a register; s2_0 is written to buf[0].
  - Neighbour row i: s2_i is written to buf[i].
- Coefficient computation in EMIT:
  - e_i = s1_src + buf[i], computed in DMVM_DATA_WIDTH+1 bits (no overflow).
  - Activation: e_i < 0 gives 0; otherwise e_i.
  - Quantise: arithmetic shift right by (DMVM_DATA_WIDTH-DATA_WIDTH), then saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Buffer read is registered; the output register is loaded one cycle ahead (prefetch), so a continuously ready sink sees one coefficient per cycle with no bubble.
- nodes == 1: EMIT emits idx 0 only, with coef_last_o=1.
- Simultaneous events: wh_valid_i during DRAIN or EMIT is held off (ready=0), never dropped.

Optional Feature:
- Macro: DMVM_LEAKY_RELU_EN.
- Defined: negative e_i is replaced by e_i >>> LEAKY_SHIFT (arithmetic shift) before quantise/saturate, so outputs can be negative.
- Undefined: plain ReLU as described; LEAKY_SHIFT has no effect.

Test Plan:
- Basic sub-graph (defaults): a1 all 1, a2 all 2, nodes=3; rows src = all 256, n1 = all 128, n2 = all -256 -> coefs 3, 2, 0; idx 0,1,2; coef_last_o on idx 2; graph_done_o pulse.
- Same stimulus with DMVM_LEAKY_RELU_EN defined -> idx 2 coefficient = -1 (-4096>>>3 = -512, >>12 = -1); idx 0 and 1 unchanged.
- Saturation: nodes=1, a1=a2 all 127, src row all 200 -> e0 = 812800 -> 198 -> saturated 127, coef_last_o=1.
- Back-pressure: basic case with coef_ready_i toggling 1,0,0,1,... -> each coefficient held stable while stalled, order 3,2,0, exactly 3 handshakes; wh_ready_o stays 0 until graph_done_o.
- Protocol errors: first row with wh_src_i=0 -> proto_err_o pulse, row dropped, next valid source row processed normally; wh_nodes_i = 169 -> proto_err_o pulse.
- Reset during EMIT after idx 1 handshake -> next cycle all outputs 0, state IDLE, wh_ready_o=0; new a_valid_i then a sub-graph produces correct coefficients.

Source files
------------

// File: rtl/dmvm_stream_if.sv
// rtl/dmvm_stream_if.sv - attention-vector load, WH row stream and coefficient stream bundle for dmvm_stream
interface dmvm_stream_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int WH_DATA_WIDTH = 12,
  parameter int NUM_FEAT      = 16,
  parameter int MAX_NODES     = 168,
  parameter int NODE_W        = $clog2(MAX_NODES + 1)
);
  logic                                a_valid_i;
  logic [2*NUM_FEAT*DATA_WIDTH-1:0]    a_i;
  logic                                wh_valid_i;
  logic                                wh_ready_o;
  logic [NUM_FEAT*WH_DATA_WIDTH-1:0]   wh_data_i;
  logic                                wh_src_i;
  logic [NODE_W-1:0]                   wh_nodes_i;
  logic                                coef_valid_o;
  logic                                coef_ready_i;
  logic [DATA_WIDTH-1:0]               coef_data_o;
  logic [NODE_W-1:0]                   coef_idx_o;
  logic                                coef_last_o;
  logic                                graph_done_o;
  logic                                proto_err_o;
  logic                                busy_o;

  modport slave (
    input  a_valid_i, a_i, wh_valid_i, wh_data_i, wh_src_i, wh_nodes_i, coef_ready_i,
    output wh_ready_o, coef_valid_o, coef_data_o, coef_idx_o, coef_last_o,
           graph_done_o, proto_err_o, busy_o
  );

  modport master (
    output a_valid_i, a_i, wh_valid_i, wh_data_i, wh_src_i, wh_nodes_i, coef_ready_i,
    input  wh_ready_o, coef_valid_o, coef_data_o, coef_idx_o, coef_last_o,
           graph_done_o, proto_err_o, busy_o
  );
endinterface

// File: rtl/dmvm_stream.sv
// rtl/dmvm_stream.sv - GAT attention-coefficient engine: WH row dot products, ReLU (LeakyReLU with DMVM_LEAKY_RELU_EN), saturating coefficient stream
module dmvm_stream #(
  parameter int DATA_WIDTH      = 8,
  parameter int WH_DATA_WIDTH   = 12,
  parameter int DMVM_DATA_WIDTH = 20,
  parameter int NUM_FEAT        = 16,
  parameter int MAX_NODES       = 168,
  parameter int NODE_W          = $clog2(MAX_NODES + 1),
  parameter int LEAKY_SHIFT     = 3
) (
  input logic          clk,
  input logic          rst_n,
  dmvm_stream_if.slave bus
);
  localparam int DW  = DMVM_DATA_WIDTH;
  localparam int LVL = $clog2(NUM_FEAT);
  localparam int PW  = DATA_WIDTH + WH_DATA_WIDTH;
  localparam int QSH = DW - DATA_WIDTH;
  localparam logic [NODE_W-1:0] MAXN = NODE_W'(MAX_NODES);
  localparam logic [NODE_W-1:0] ONE  = NODE_W'(1);
  localparam logic signed [DW:0] QMAX = (DW+1)'((2**(DATA_WIDTH-1)) - 1);
  localparam logic signed [DW:0] QMIN = -(DW+1)'(2**(DATA_WIDTH-1));

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, EMIT} state_t;

  state_t                           state_q, state_d;
  logic [2*NUM_FEAT*DATA_WIDTH-1:0] a_q, a_d;
  logic [NODE_W-1:0]                rows_q, rows_d, nodes_q, nodes_d;
  logic [NODE_W-1:0]                rd_ptr_q, rd_ptr_d, rd_idx_q, rd_idx_d, coef_idx_q, coef_idx_d;
  logic                             rd_v_q, rd_v_d, coef_v_q, coef_v_d, coef_last_q, coef_last_d;
  logic                             done_q, done_d, err_q, err_d;
  logic signed [DATA_WIDTH-1:0]     coef_q, coef_d;
  logic signed [DW-1:0]             s1_q, s1_d, rd_data_q, rd_data_d;
  logic signed [DW-1:0]             t1_q [LVL+1][NUM_FEAT], t1_d [LVL+1][NUM_FEAT];
  logic signed [DW-1:0]             t2_q [LVL+1][NUM_FEAT], t2_d [LVL+1][NUM_FEAT];
  logic [LVL:0]                     pv_q, pv_d, psrc_q, psrc_d;
  logic [NODE_W-1:0]                pidx_q [LVL+1], pidx_d [LVL+1];
  logic signed [DW-1:0]             score_mem [MAX_NODES];
  logic signed [PW-1:0]             p1, p2;
  logic signed [DW:0]               e_sum, e_act, e_shr;
  logic                             wh_ready, wh_hs, push, rd_issue, out_load, coef_hs;

  assign wh_ready = (state_q == ACCUM) && ((rows_q == '0) || (rows_q < nodes_q));
  assign wh_hs    = bus.wh_valid_i && wh_ready;
  assign coef_hs  = coef_v_q && bus.coef_ready_i;
  assign out_load = rd_v_q && (!coef_v_q || bus.coef_ready_i);
  assign rd_issue = (state_q == EMIT) && (rd_ptr_q < nodes_q) && (!rd_v_q || out_load);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    rows_d  = rows_q;
    nodes_d = nodes_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.a_valid_i) begin
          a_d     = bus.a_i;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (bus.a_valid_i && rows_q == '0) a_d = bus.a_i;
        if (wh_hs) begin
          // Offending rows complete their handshake but leave every counter untouched.
          if (rows_q == '0) begin
            if (!bus.wh_src_i || bus.wh_nodes_i == '0 || bus.wh_nodes_i > MAXN) begin
              err_d = 1'b1;
            end else begin
              push    = 1'b1;
              nodes_d = bus.wh_nodes_i;
              rows_d  = ONE;
              if (bus.wh_nodes_i == ONE) state_d = DRAIN;
            end
          end else if (bus.wh_src_i) begin
            err_d = 1'b1;
          end else begin
            push   = 1'b1;
            rows_d = rows_q + ONE;
            if (rows_d == nodes_q) state_d = DRAIN;
          end
        end
      end
      DRAIN: if (pv_q == '0) state_d = EMIT;
      EMIT: begin
        if (coef_hs && coef_last_q) begin
          done_d  = 1'b1;
          rows_d  = '0;
          state_d = ACCUM;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    p1 = '0;
    p2 = '0;
    for (int l = 0; l <= LVL; l++) begin
      for (int k = 0; k < NUM_FEAT; k++) begin
        t1_d[l][k] = '0;
        t2_d[l][k] = '0;
      end
    end
    for (int k = 0; k < NUM_FEAT; k++) begin
      p1 = $signed(a_q[k*DATA_WIDTH +: DATA_WIDTH]) *
           $signed(bus.wh_data_i[k*WH_DATA_WIDTH +: WH_DATA_WIDTH]);
      p2 = $signed(a_q[(NUM_FEAT+k)*DATA_WIDTH +: DATA_WIDTH]) *
           $signed(bus.wh_data_i[k*WH_DATA_WIDTH +: WH_DATA_WIDTH]);
      t1_d[0][k] = DW'(p1);
      t2_d[0][k] = DW'(p2);
    end
    for (int l = 1; l <= LVL; l++) begin
      for (int k = 0; k < NUM_FEAT / 2; k++) begin
        if (k < (NUM_FEAT >> l)) begin
          t1_d[l][k] = t1_q[l-1][2*k] + t1_q[l-1][2*k+1];
          t2_d[l][k] = t2_q[l-1][2*k] + t2_q[l-1][2*k+1];
        end
      end
    end
    pv_d      = {pv_q[LVL-1:0], push};
    psrc_d    = {psrc_q[LVL-1:0], rows_q == '0};
    pidx_d[0] = rows_q;
    for (int l = 1; l <= LVL; l++) pidx_d[l] = pidx_q[l-1];
    s1_d = (pv_q[LVL] && psrc_q[LVL]) ? t1_q[LVL][0] : s1_q;
  end

  always_comb begin
    e_sum = (DW+1)'(s1_q) + (DW+1)'(rd_data_q);
    if (e_sum[DW]) begin
`ifdef DMVM_LEAKY_RELU_EN
      e_act = e_sum >>> LEAKY_SHIFT;
`else
      e_act = '0;
`endif
    end else begin
      e_act = e_sum;
    end
    e_shr = e_act >>> QSH;
    if (e_shr > QMAX)      coef_d = DATA_WIDTH'(QMAX);
    else if (e_shr < QMIN) coef_d = DATA_WIDTH'(QMIN);
    else                   coef_d = DATA_WIDTH'(e_shr);
    if (!out_load) coef_d = coef_q;

    // Read stage runs one entry ahead of the output register so a ready sink never sees a bubble.
    rd_data_d   = rd_issue ? score_mem[rd_ptr_q] : rd_data_q;
    rd_idx_d    = rd_issue ? rd_ptr_q : rd_idx_q;
    rd_ptr_d    = done_d ? '0 : (rd_issue ? rd_ptr_q + ONE : rd_ptr_q);
    rd_v_d      = rd_issue ? 1'b1 : (out_load ? 1'b0 : rd_v_q);
    coef_v_d    = out_load ? 1'b1 : (coef_hs ? 1'b0 : coef_v_q);
    coef_idx_d  = out_load ? rd_idx_q : coef_idx_q;
    coef_last_d = out_load ? (rd_idx_q == nodes_q - ONE) : coef_last_q;
  end

  always_ff @(posedge clk) begin
    t1_q      <= t1_d;
    t2_q      <= t2_d;
    pidx_q    <= pidx_d;
    s1_q      <= s1_d;
    rd_data_q <= rd_data_d;
    rd_idx_q  <= rd_idx_d;
    if (pv_q[LVL]) score_mem[pidx_q[LVL]] <= t2_q[LVL][0];
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      rows_q      <= '0;
      nodes_q     <= '0;
      rd_ptr_q    <= '0;
      rd_v_q      <= 1'b0;
      coef_v_q    <= 1'b0;
      coef_q      <= '0;
      coef_idx_q  <= '0;
      coef_last_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      pv_q        <= '0;
      psrc_q      <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      rows_q      <= rows_d;
      nodes_q     <= nodes_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_v_q      <= rd_v_d;
      coef_v_q    <= coef_v_d;
      coef_q      <= coef_d;
      coef_idx_q  <= coef_idx_d;
      coef_last_q <= coef_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
      pv_q        <= pv_d;
      psrc_q      <= psrc_d;
    end
  end

  assign bus.wh_ready_o   = wh_ready;
  assign bus.coef_valid_o = coef_v_q;
  assign bus.coef_data_o  = coef_q;
  assign bus.coef_idx_o   = coef_idx_q;
  assign bus.coef_last_o  = coef_last_q;
  assign bus.graph_done_o = done_q;
  assign bus.proto_err_o  = err_q;
  assign bus.busy_o       = (state_q != IDLE) && !(state_q == ACCUM && rows_q == '0);
endmodule

// File: tb/tb_dmvm_stream.sv
// tb/tb_dmvm_stream.sv - self-checking bench for dmvm_stream (table vectors, hand sequences, randomized graphs)
module tb_dmvm_stream;
  localparam int DW   = 8;
  localparam int WW   = 12;
  localparam int NF   = 16;
  localparam int MAXN = 168;
  localparam int NW   = $clog2(MAXN + 1);
`ifdef DMVM_LEAKY_RELU_EN
  localparam bit LEAKY = 1'b1;
`else
  localparam bit LEAKY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmvm_stream_if #(.DATA_WIDTH(DW), .WH_DATA_WIDTH(WW), .NUM_FEAT(NF), .MAX_NODES(MAXN)) bus ();
  dmvm_stream #(.DATA_WIDTH(DW), .WH_DATA_WIDTH(WW), .DMVM_DATA_WIDTH(20), .NUM_FEAT(NF),
                .MAX_NODES(MAXN), .LEAKY_SHIFT(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad = 0;
  int ta1 [NF];
  int ta2 [NF];
  int wh [MAXN][NF];
  int exp_q [$];

  typedef struct {
    int a1v, a2v, nodes;
    int r0, r1, r2;
    int e0, e1, e2;
    int l0, l1, l2;
  } vec_t;
  vec_t vt [5];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic longint dotp(input bit second, input int r);
    longint s = 0;
    for (int k = 0; k < NF; k++) s += longint'(second ? ta2[k] : ta1[k]) * longint'(wh[r][k]);
    s = s % 1048576;
    if (s < 0) s += 1048576;
    if (s >= 524288) s -= 1048576;
    return s;
  endfunction

  function automatic int coef_model(input int i);
    longint e = dotp(1'b0, 0) + dotp(1'b1, i);
    longint q;
    if (e < 0) e = LEAKY ? (e >>> 3) : 0;
    q = e >>> 12;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return int'(q);
  endfunction

  task automatic load_a;
    for (int k = 0; k < NF; k++) begin
      bus.a_i[k*DW +: DW]      = DW'(ta1[k]);
      bus.a_i[(NF+k)*DW +: DW] = DW'(ta2[k]);
    end
    bus.a_valid_i = 1'b1;
    tick;
    bus.a_valid_i = 1'b0;
  endtask

  task automatic send_row(input int r, input bit src, input int nodes);
    int n = 0;
    for (int k = 0; k < NF; k++) bus.wh_data_i[k*WW +: WW] = WW'(wh[r][k]);
    bus.wh_src_i   = src;
    bus.wh_nodes_i = NW'(nodes);
    bus.wh_valid_i = 1'b1;
    while (!bus.wh_ready_o && n < 200) begin
      tick;
      n++;
    end
    if (!bus.wh_ready_o) check("wh_ready_timeout", 0, 1);
    tick;
    bus.wh_valid_i = 1'b0;
    bus.wh_src_i   = 1'b0;
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready
  task automatic collect(input int n, input int mode);
    int got = 0;
    int cyc = 0;
    bit stall = 1'b0;
    bit rdy;
    logic [DW-1:0] sd;
    logic [NW-1:0] si;
    while (got < n && cyc < 3000) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.coef_ready_i = rdy;
      check("wh_ready_during_emit", bus.wh_ready_o, 0);
      if (bus.coef_valid_o) begin
        if (stall) begin
          check("hold_data", bus.coef_data_o, sd);
          check("hold_idx", bus.coef_idx_o, si);
        end
        if (rdy) begin
          check("coef_data", $signed(bus.coef_data_o), exp_q[got]);
          check("coef_idx", bus.coef_idx_o, got);
          check("coef_last", bus.coef_last_o, (got == n - 1));
          got++;
        end
        stall = !rdy;
        sd = bus.coef_data_o;
        si = bus.coef_idx_o;
      end else begin
        stall = 1'b0;
      end
      tick;
      cyc++;
    end
    bus.coef_ready_i = 1'b0;
    if (got < n) check("emit_timeout", got, n);
    check("graph_done", bus.graph_done_o, 1);
    check("valid_after_done", bus.coef_valid_o, 0);
    tick;
    check("graph_done_pulse", bus.graph_done_o, 0);
  endtask

  task automatic run_graph(input int n, input int mode);
    for (int i = 0; i < n; i++) send_row(i, (i == 0), n);
    collect(n, mode);
  endtask

  task automatic set_uniform(input int a1v, input int a2v, input int r0, input int r1, input int r2);
    for (int k = 0; k < NF; k++) begin
      ta1[k] = a1v;
      ta2[k] = a2v;
      wh[0][k] = r0;
      wh[1][k] = r1;
      wh[2][k] = r2;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_coef_valid"}, bus.coef_valid_o, 0);
    check({tag, "_coef_data"}, bus.coef_data_o, 0);
    check({tag, "_coef_idx"}, bus.coef_idx_o, 0);
    check({tag, "_coef_last"}, bus.coef_last_o, 0);
    check({tag, "_graph_done"}, bus.graph_done_o, 0);
    check({tag, "_proto_err"}, bus.proto_err_o, 0);
    check({tag, "_busy"}, bus.busy_o, 0);
    check({tag, "_wh_ready"}, bus.wh_ready_o, 0);
  endtask

  initial begin
    int hs;
    int n;
    bus.a_valid_i = 1'b0;
    bus.a_i = '0;
    bus.wh_valid_i = 1'b0;
    bus.wh_data_i = '0;
    bus.wh_src_i = 1'b0;
    bus.wh_nodes_i = '0;
    bus.coef_ready_i = 1'b0;

    vt[0] = '{1, 2, 3, 256, 128, -256, 3, 2, 0, 3, 2, -1};
    vt[1] = '{127, 127, 1, 200, 0, 0, 127, 0, 0, 127, 0, 0};
    vt[2] = '{-1, 1, 2, 1000, 2047, 0, 0, 4, 0, 0, 4, 0};
    vt[3] = '{127, 127, 1, 2047, 0, 0, 0, 0, 0, -3, 0, 0};
    vt[4] = '{0, -128, 2, -1000, 100, 0, 0, 0, 0, -2, -7, 0};

    tick; tick; tick;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick;
    check("idle_wh_ready", bus.wh_ready_o, 0);

    foreach (vt[v]) begin
      set_uniform(vt[v].a1v, vt[v].a2v, vt[v].r0, vt[v].r1, vt[v].r2);
      load_a;
      check("accum_wh_ready", bus.wh_ready_o, 1);
      exp_q.delete();
      exp_q.push_back(LEAKY ? vt[v].l0 : vt[v].e0);
      exp_q.push_back(LEAKY ? vt[v].l1 : vt[v].e1);
      exp_q.push_back(LEAKY ? vt[v].l2 : vt[v].e2);
      run_graph(vt[v].nodes, 0);
    end

    // Back-pressure on the basic sub-graph
    set_uniform(1, 2, 256, 128, -256);
    load_a;
    exp_q.delete();
    exp_q.push_back(3);
    exp_q.push_back(2);
    exp_q.push_back(LEAKY ? -1 : 0);
    run_graph(3, 1);

    // Protocol errors: each offending row is swallowed and the graph still completes
    send_row(0, 1'b0, 3);
    check("err_no_src", bus.proto_err_o, 1);
    check("err_no_src_busy", bus.busy_o, 0);
    tick;
    check("err_pulse_width", bus.proto_err_o, 0);
    send_row(0, 1'b1, 169);
    check("err_nodes_169", bus.proto_err_o, 1);
    send_row(0, 1'b1, 0);
    check("err_nodes_0", bus.proto_err_o, 1);
    send_row(0, 1'b1, 3);
    check("src_ok_no_err", bus.proto_err_o, 0);
    send_row(1, 1'b1, 3);
    check("err_src_repeat", bus.proto_err_o, 1);
    send_row(1, 1'b0, 3);
    send_row(2, 1'b0, 3);
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(coef_model(i));
    collect(3, 0);

    // Reset mid-EMIT after the idx 1 handshake
    for (int i = 0; i < 3; i++) send_row(i, (i == 0), 3);
    hs = 0;
    n = 0;
    bus.coef_ready_i = 1'b1;
    while (hs < 2 && n < 200) begin
      if (bus.coef_valid_o) hs++;
      tick;
      n++;
    end
    check("reset_emit_handshakes", hs, 2);
    bus.coef_ready_i = 1'b0;
    rst_n = 1'b0;
    tick;
    check_idle_outputs("mid_reset");
    rst_n = 1'b1;
    tick;
    check("post_reset_wh_ready", bus.wh_ready_o, 0);
    for (int k = 0; k < NF; k++) begin
      ta1[k] = 3;
      ta2[k] = -1;
    end
    load_a;
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(coef_model(i));
    run_graph(3, 0);

    // Randomized graphs against the arithmetic model
    for (int t = 0; t < 10; t++) begin
      int nodes;
      nodes = (t == 0) ? MAXN : int'($urandom_range(1, 12));
      for (int k = 0; k < NF; k++) begin
        ta1[k] = int'($urandom_range(0, 255)) - 128;
        ta2[k] = int'($urandom_range(0, 255)) - 128;
      end
      for (int i = 0; i < nodes; i++)
        for (int k = 0; k < NF; k++) wh[i][k] = int'($urandom_range(0, 4095)) - 2048;
      load_a;
      exp_q.delete();
      for (int i = 0; i < nodes; i++) exp_q.push_back(coef_model(i));
      run_graph(nodes, (t % 2 == 0) ? 2 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
